// File: rtl/smartcard_seq.sv
// rtl/smartcard_seq.sv - smart-card session sequencer: activation, guarded TX, ATR/CWT timeouts, deactivation
`timescale 1ns/1ps
module smartcard_seq #(
    parameter int CLK_DIV         = 372,
    parameter int T_VCC_CYC       = 4096,
    parameter int T_RST_LOW_CYC   = 40000,
    parameter int ATR_TIMEOUT_CYC = 40000,
    parameter int T_DEACT_CYC     = 256,
    parameter int GUARD_ETU       = 2,
    parameter int CWT_ETU         = 9600,
    parameter int TIMER_BITS      = 24
) (
    input  logic       baseclk,
    input  logic       reset,
    input  logic       cmd_activate,
    input  logic       cmd_deactivate,
    output logic [2:0] state,
    output logic       card_vcc_en,
    output logic       card_clk_en,
    output logic       card_rst_n,
    output logic       uart_reset,
    output logic       atr_timeout,
    output logic       cwt_timeout,
    input  logic [7:0] host_tx_data,
    input  logic       host_tx_valid,
    output logic       host_tx_ready,
    output logic [7:0] host_rx_data,
    output logic       host_rx_valid,
    input  logic       host_rx_ready,
    output logic       host_rx_parerr,
    output logic [7:0] uart_tx_data,
    output logic       uart_tx_valid,
    input  logic       uart_tx_ready,
    input  logic [7:0] uart_rx_data,
    input  logic       uart_rx_valid,
    output logic       uart_rx_ready,
    input  logic       uart_parity_error
);

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_VCC_UP    = 3'd1,
        ST_RST_LOW   = 3'd2,
        ST_ATR_WAIT  = 3'd3,
        ST_ACTIVE    = 3'd4,
        ST_DEACT_RST = 3'd5,
        ST_DEACT_CLK = 3'd6
    } state_t;

    // Phase lengths are compared against the timer value of the last cycle of the phase.
    localparam logic [TIMER_BITS-1:0] VCC_LAST     = TIMER_BITS'(T_VCC_CYC - 1);
    localparam logic [TIMER_BITS-1:0] RST_LOW_LAST = TIMER_BITS'(T_RST_LOW_CYC - 1);
    localparam logic [TIMER_BITS-1:0] ATR_LAST     = TIMER_BITS'(ATR_TIMEOUT_CYC - 1);
    localparam logic [TIMER_BITS-1:0] DEACT_LAST   = TIMER_BITS'(T_DEACT_CYC - 1);
    localparam logic [TIMER_BITS-1:0] GUARD_LOAD   = TIMER_BITS'(GUARD_ETU * CLK_DIV);

    localparam int PRESC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int ETU_W   = $clog2(CWT_ETU + 1);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_DIV - 1);
    localparam logic [ETU_W-1:0]   ETU_LAST   = ETU_W'(CWT_ETU - 1);
    localparam logic [ETU_W-1:0]   ETU_MAX    = ETU_W'(CWT_ETU);

    state_t                  state_q, state_d;
    logic [TIMER_BITS-1:0]   timer_q;
    logic                    vcc_en_q, clk_en_q, rst_n_q, uart_reset_q;
    logic                    atr_timeout_q, cwt_timeout_q;
    logic                    tx_busy_q, tx_armed_q;
    logic [TIMER_BITS-1:0]   guard_cnt_q;
    logic [PRESC_W-1:0]      presc_q;
    logic [ETU_W-1:0]        etu_q;

    logic active, rx_window, deact_req, atr_expire, rx_hs, tx_hs;

    assign active    = (state_q == ST_ACTIVE);
    assign rx_window = (state_q == ST_ATR_WAIT) || active;
    assign deact_req = cmd_deactivate &&
                       (state_q inside {ST_VCC_UP, ST_RST_LOW, ST_ATR_WAIT, ST_ACTIVE});

    // Byte streams: RX is passed through only while a card session is open, otherwise drained.
    assign host_rx_data   = uart_rx_data;
    assign host_rx_valid  = uart_rx_valid && rx_window;
    assign uart_rx_ready  = rx_window ? host_rx_ready : 1'b1;
    assign host_rx_parerr = uart_parity_error;
    assign host_tx_ready  = active && uart_tx_ready && !tx_busy_q && (guard_cnt_q == '0);
    assign uart_tx_valid  = host_tx_valid && host_tx_ready;
    assign uart_tx_data   = host_tx_data;
    assign rx_hs          = host_rx_valid && host_rx_ready;
    assign tx_hs          = uart_tx_valid;

    assign state       = state_q;
    assign card_vcc_en = vcc_en_q;
    assign card_clk_en = clk_en_q;
    assign card_rst_n  = rst_n_q;
    assign uart_reset  = uart_reset_q;
    assign atr_timeout = atr_timeout_q;
    assign cwt_timeout = cwt_timeout_q;

    // Next-state selection; deactivation requests take priority over every other exit.
    always_comb begin
        state_d    = state_q;
        atr_expire = 1'b0;
        case (state_q)
            ST_OFF: begin
                if (cmd_activate && !cmd_deactivate) state_d = ST_VCC_UP;
            end
            ST_VCC_UP: begin
                if (deact_req)                state_d = ST_DEACT_RST;
                else if (timer_q == VCC_LAST) state_d = ST_RST_LOW;
            end
            ST_RST_LOW: begin
                if (deact_req)                    state_d = ST_DEACT_RST;
                else if (timer_q == RST_LOW_LAST) state_d = ST_ATR_WAIT;
            end
            ST_ATR_WAIT: begin
                if (deact_req)          state_d = ST_DEACT_RST;
                else if (uart_rx_valid) state_d = ST_ACTIVE;
                else if (timer_q == ATR_LAST) begin
                    state_d    = ST_DEACT_RST;
                    atr_expire = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (deact_req) state_d = ST_DEACT_RST;
            end
            ST_DEACT_RST: begin
                if (timer_q == DEACT_LAST) state_d = ST_DEACT_CLK;
            end
            ST_DEACT_CLK: begin
                if (timer_q == DEACT_LAST) state_d = ST_OFF;
            end
            default: state_d = ST_OFF;
        endcase
    end

    // Session FSM: state, phase timer and card pins, all decoded from the state being entered.
    always_ff @(posedge baseclk) begin
        if (reset) begin
            state_q       <= ST_OFF;
            timer_q       <= '0;
            vcc_en_q      <= 1'b0;
            clk_en_q      <= 1'b0;
            rst_n_q       <= 1'b0;
            uart_reset_q  <= 1'b1;
            atr_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= (state_d != state_q || state_d == ST_OFF) ? '0 : timer_q + 1'b1;
            vcc_en_q      <= (state_d != ST_OFF);
            clk_en_q      <= (state_d inside {ST_RST_LOW, ST_ATR_WAIT, ST_ACTIVE, ST_DEACT_RST});
            rst_n_q       <= (state_d inside {ST_ATR_WAIT, ST_ACTIVE});
            uart_reset_q  <= !(state_d inside {ST_RST_LOW, ST_ATR_WAIT, ST_ACTIVE});
            atr_timeout_q <= atr_expire;
        end
    end

    // TX pacing: hold off until the UART has taken the byte, then add the guard time.
    always_ff @(posedge baseclk) begin
        if (reset) begin
            tx_busy_q   <= 1'b0;
            tx_armed_q  <= 1'b0;
            guard_cnt_q <= '0;
        end else begin
            if (tx_hs) begin
                tx_busy_q  <= 1'b1;
                tx_armed_q <= 1'b0;
            end else if (tx_busy_q) begin
                tx_armed_q <= 1'b1;
                if (tx_armed_q && uart_tx_ready) tx_busy_q <= 1'b0;
            end
            if (tx_busy_q && tx_armed_q && uart_tx_ready) guard_cnt_q <= GUARD_LOAD;
            else if (guard_cnt_q != '0)                    guard_cnt_q <= guard_cnt_q - 1'b1;
        end
    end

    // Character-waiting timer: counts ETUs of silence in ACTIVE and fires once per quiet window.
    always_ff @(posedge baseclk) begin
        if (reset) begin
            presc_q       <= '0;
            etu_q         <= '0;
            cwt_timeout_q <= 1'b0;
        end else begin
            cwt_timeout_q <= 1'b0;
            if (!active || rx_hs || tx_hs) begin
                presc_q <= '0;
                etu_q   <= '0;
            end else if (etu_q != ETU_MAX) begin
                if (presc_q == PRESC_LAST) begin
                    presc_q <= '0;
                    etu_q   <= etu_q + 1'b1;
                    if (etu_q == ETU_LAST) cwt_timeout_q <= 1'b1;
                end else begin
                    presc_q <= presc_q + 1'b1;
                end
            end
        end
    end

endmodule
